// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage interlock for load-use, ID-compared branches and the
// multi-cycle multiply/divide unit, tracking EX/MEM destinations in its own shadow slots.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       UsesRsD,
    input  logic       UsesRtD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic [4:0] rwD,
    input  logic       BranchD,
    input  logic       MdStartD,
    input  logic       MdReadD,
    input  logic       FlushD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       MdBusy
);

    localparam logic [CNT_W-1:0] LP_MD_LOAD = CNT_W'(MD_LATENCY);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    logic             r_ex_v;
    logic             r_ex_regwrite;
    logic             r_ex_memtoreg;
    logic [4:0]       r_ex_rw;
    logic             r_mem_v;
    logic             r_mem_regwrite;
    logic             r_mem_memtoreg;
    logic [4:0]       r_mem_rw;
    logic [CNT_W-1:0] r_mdcnt;

    logic w_match_ex;
    logic w_match_mem;
    logic w_lwstall;
    logic w_brstall;
    logic w_mdstall;
    logic w_md_nz;
    logic w_stall;
    logic w_accept;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    function automatic logic src_match(input logic [4:0] x, input logic [4:0] a,
                                       input logic [4:0] b, input logic use_a,
                                       input logic use_b);
        return (x != 5'd0) && ((use_a && (x == a)) || (use_b && (x == b)));
    endfunction

    always_comb begin
        w_match_ex  = src_match(r_ex_rw, rs, rt, UsesRsD, UsesRtD);
        w_match_mem = src_match(r_mem_rw, rs, rt, UsesRsD, UsesRtD);
        w_md_nz     = (r_mdcnt != '0);
        w_lwstall   = r_ex_v && r_ex_memtoreg && w_match_ex;
        w_brstall   = BranchD && ((r_ex_v && r_ex_regwrite && w_match_ex) ||
                                  (r_mem_v && r_mem_memtoreg && w_match_mem));
        w_mdstall   = (MdReadD || MdStartD) && w_md_nz;
        w_stall     = !FlushD && (w_lwstall || w_brstall || w_mdstall);
        w_accept    = !w_stall && !FlushD;
    end

    assign StallF = w_stall;
    assign StallD = w_stall;
    assign FlushE = w_stall;
    assign MdBusy = w_md_nz;

    // NOTE: state registers use non-blocking assignments so every slot samples
    // the pre-edge values, letting EX shift into MEM in the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_v         <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memtoreg  <= 1'b0;
            r_ex_rw        <= 5'd0;
            r_mem_v        <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_rw       <= 5'd0;
            r_mdcnt        <= '0;
        end else begin
            if (w_accept) begin
                r_ex_v        <= 1'b1;
                r_ex_regwrite <= RegWriteD;
                r_ex_memtoreg <= MemtoRegD;
                r_ex_rw       <= rwD;
            end else begin
                r_ex_v        <= 1'b0;
                r_ex_regwrite <= 1'b0;
                r_ex_memtoreg <= 1'b0;
                r_ex_rw       <= 5'd0;
            end
            r_mem_v        <= r_ex_v;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_rw       <= r_ex_rw;
            if (w_accept && MdStartD) begin
                r_mdcnt <= LP_MD_LOAD;
            end else if (w_md_nz) begin
                r_mdcnt <= r_mdcnt - LP_ONE;
            end
        end
    end

endmodule
